// File: rtl/sig_gen_pkg.sv
// Shared constants and helpers for the signal-generator audio path.
// Holds the I2S slot geometry and the per-bit slot mapping used by the serializer.
package sig_gen_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    // Bit 0 of each slot is the I2S one-BCLK delay; sample bits follow MSB first, then zero pad.
    function automatic logic slot_bit(input logic [SLOT_BITS-1:0] word,
                                      input logic [4:0]           b,
                                      input int                   depth);
        logic [4:0] idx;
        idx = 5'(depth - int'(b));
        if (int'(b) >= 1 && int'(b) <= depth)
            return word[idx];
        return 1'b0;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for queued sample words.
// The head entry is visible combinationally, so a pop captures it with no read latency.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/i2s_sample_tx.sv
// I2S transmitter: BCLK divider, 64-bit frame counter and serializer fed from a sample FIFO.
// Each popped word is sent in both slots; the frame-start pulse doubles as the upstream sample strobe.
module i2s_sample_tx
    import sig_gen_pkg::*;
#(
    parameter int BIT_DEPTH  = 24,
    parameter int BCLK_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] sample_i,
    input  logic        sample_valid_i,
    output logic        sample_ready_o,
    output logic        sample_tick_o,
    output logic        underrun_o,
    output logic        bclk_o,
    output logic        lrclk_o,
    output logic        sdata_o
);

    localparam int DW = $clog2(BCLK_DIV);

    logic [DW-1:0]        div_cnt;
    logic [5:0]           bit_cnt;
    logic [5:0]           bit_nxt;
    logic [SLOT_BITS-1:0] frame_word;
    logic [SLOT_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 div_wrap;
    logic                 bclk_fall;
    logic                 frame_start;

    assign div_wrap       = (div_cnt == DW'(BCLK_DIV - 1));
    assign bclk_fall      = div_wrap && bclk_o;
    assign frame_start    = bclk_fall && (bit_cnt == 6'(FRAME_BITS - 1));
    assign bit_nxt        = bit_cnt + 6'd1;
    assign sample_ready_o = !fifo_full;
    assign lrclk_o        = bit_cnt[5];

    // An empty FIFO at frame start is not bypassed: a same-cycle push waits for the next frame.
    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SLOT_BITS)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (sample_valid_i),
        .pop   (frame_start),
        .din   (sample_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt       <= '0;
            bclk_o        <= 1'b0;
            bit_cnt       <= 6'(FRAME_BITS - 1);
            sdata_o       <= 1'b0;
            sample_tick_o <= 1'b0;
            underrun_o    <= 1'b0;
            frame_word    <= '0;
        end else begin
            sample_tick_o <= frame_start;
            div_cnt       <= div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap)
                bclk_o <= !bclk_o;
            // Data and word select both move on the falling BCLK edge.
            if (bclk_fall) begin
                bit_cnt <= bit_nxt;
                sdata_o <= slot_bit(frame_word, bit_nxt[4:0], BIT_DEPTH);
            end
            if (frame_start) begin
                frame_word <= fifo_empty ? '0 : fifo_head;
                if (fifo_empty)
                    underrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Scoreboard bench for i2s_sample_tx: stimulus queues expected slot words, a monitor
// deserializes each frame on BCLK rising edges and compares both slots and word select.
module tb_i2s_sample_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] sample_i = '0;
    logic        sample_valid_i = 1'b0;
    logic        sample_ready_o;
    logic        sample_tick_o;
    logic        underrun_o;
    logic        bclk_o;
    logic        lrclk_o;
    logic        sdata_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    i2s_sample_tx #(
        .BIT_DEPTH  (24),
        .BCLK_DIV   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .sample_tick_o  (sample_tick_o),
        .underrun_o     (underrun_o),
        .bclk_o         (bclk_o),
        .lrclk_o        (lrclk_o),
        .sdata_o        (sdata_o)
    );

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [31:0] slot_exp(input logic [31:0] w);
        return {1'b0, w[23:0], 7'b0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: frame capture starts at the tick, one bit per BCLK rise, aborted by reset.
    initial begin
        int          idx;
        logic        pb;
        logic [63:0] bits;
        logic [63:0] lr;
        logic [31:0] e;
        idx = -1;
        pb  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                idx = -1;
                pb  = 1'b0;
            end else begin
                if (sample_tick_o) idx = 0;
                if (bclk_o && !pb && idx >= 0 && idx < 64) begin
                    bits[63-idx] = sdata_o;
                    lr[63-idx]   = lrclk_o;
                    idx++;
                    if (idx == 64) begin
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("left_slot", {32'h0, bits[63:32]}, {32'h0, e});
                            chk("right_slot", {32'h0, bits[31:0]}, {32'h0, e});
                            chk("lrclk_pattern", lr, 64'h0000_0000_FFFF_FFFF);
                        end
                        idx = -1;
                    end
                end
                pb = bclk_o;
            end
        end
    end

    task automatic at_cyc(input int k);
        int n;
        n = 0;
        while (cyc != k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != k) chk("cycle_wait_timeout", 64'(cyc), 64'(k));
    endtask

    task automatic push_at(input int k, input logic [31:0] w);
        at_cyc(k - 1);
        sample_i       = w;
        sample_valid_i = 1'b1;
        @(negedge clk);
        sample_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        sample_valid_i = 1'b0;
        #1;
        chk("rst_bclk", 64'(bclk_o), 64'd0);
        chk("rst_lrclk", 64'(lrclk_o), 64'd1);
        chk("rst_sdata", 64'(sdata_o), 64'd0);
        chk("rst_tick", 64'(sample_tick_o), 64'd0);
        chk("rst_underrun", 64'(underrun_o), 64'd0);
        chk("rst_ready", 64'(sample_ready_o), 64'd1);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_timing();
        at_cyc(1);   chk("bclk_c1", 64'(bclk_o), 64'd0);
        at_cyc(2);   chk("bclk_rise_c2", 64'(bclk_o), 64'd1);
                     chk("lrclk_c2", 64'(lrclk_o), 64'd1);
        at_cyc(3);   chk("tick_c3", 64'(sample_tick_o), 64'd0);
                     chk("underrun_c3", 64'(underrun_o), 64'd0);
        at_cyc(4);   chk("tick_c4", 64'(sample_tick_o), 64'd1);
                     chk("bclk_fall_c4", 64'(bclk_o), 64'd0);
                     chk("lrclk_c4", 64'(lrclk_o), 64'd0);
                     chk("underrun_c4", 64'(underrun_o), 64'd1);
        at_cyc(5);   chk("tick_c5", 64'(sample_tick_o), 64'd0);
        at_cyc(259); chk("tick_c259", 64'(sample_tick_o), 64'd0);
        at_cyc(260); chk("tick_c260", 64'(sample_tick_o), 64'd1);
    endtask

    initial begin
        logic [31:0] w [5];
        w[0] = 32'h0011_1111; w[1] = 32'h0080_0001; w[2] = 32'h007F_FFFE;
        w[3] = 32'h0000_0001; w[4] = 32'h00DE_AD00;

        // Reset values, divider/tick timing, empty FIFO gives zero frames
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        check_timing();
        wait_drain();

        // Single sample before the first frame; upper input bits are ignored in the second
        do_reset();
        exp_q.push_back(32'h52F8_0780);
        exp_q.push_back(32'h091A_2B00);
        exp_q.push_back(32'h0);
        push_at(2, 32'h00A5_F00F);
        push_at(3, 32'hFF12_3456);
        at_cyc(500);
        chk("single_underrun_clear", 64'(underrun_o), 64'd0);
        wait_drain();

        // Underrun is sticky through later pushes
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(slot_exp(32'h00C0_FFEE));
        push_at(10, 32'h00C0_FFEE);
        at_cyc(300);
        chk("underrun_sticky", 64'(underrun_o), 64'd1);
        wait_drain();

        // Full FIFO: five back-to-back words, the fifth is dropped
        do_reset();
        exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) exp_q.push_back(slot_exp(w[i]));
        exp_q.push_back(32'h0);
        at_cyc(5);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) chk("ready_three_queued", 64'(sample_ready_o), 64'd1);
            if (i == 4) chk("ready_full", 64'(sample_ready_o), 64'd0);
            sample_i       = w[i];
            sample_valid_i = 1'b1;
            @(negedge clk);
        end
        sample_valid_i = 1'b0;
        chk("ready_still_full", 64'(sample_ready_o), 64'd0);
        at_cyc(261);
        chk("ready_after_pop", 64'(sample_ready_o), 64'd1);
        wait_drain();

        // One word queued, push in the tick cycle: count stays at one
        do_reset();
        exp_q.push_back(slot_exp(32'h00A0_0005));
        exp_q.push_back(slot_exp(w[0]));
        exp_q.push_back(slot_exp(w[1]));
        exp_q.push_back(slot_exp(w[2]));
        exp_q.push_back(slot_exp(w[3]));
        exp_q.push_back(32'h0);
        push_at(2, 32'h00A0_0005);
        push_at(4, w[0]);
        push_at(6, w[1]);
        push_at(7, w[2]);
        chk("ready_count3", 64'(sample_ready_o), 64'd1);
        push_at(8, w[3]);
        chk("ready_count4", 64'(sample_ready_o), 64'd0);
        wait_drain();
        chk("simul_no_underrun_until_empty", 64'(underrun_o), 64'd1);

        // Empty FIFO, push in the tick cycle: underrun, word goes out next frame
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(slot_exp(32'h0012_3400));
        push_at(4, 32'h0012_3400);
        chk("empty_tick_underrun", 64'(underrun_o), 64'd1);
        wait_drain();

        // Mid-frame reset with three words queued
        do_reset();
        push_at(1, w[0]);
        push_at(2, w[1]);
        push_at(3, w[2]);
        push_at(5, w[3]);
        at_cyc(163);
        chk("mid_lrclk_right", 64'(lrclk_o), 64'd1);
        chk("mid_underrun", 64'(underrun_o), 64'd0);
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        check_timing();
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
